// File: rtl/pc_seq_pkg.sv
// Shared opcode encoding and sizing helpers for the PC sequencer and its decoder.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    NEXT   = 3'd0,
    BR_REL = 3'd1,
    JMP    = 3'd2,
    CALL   = 3'd3,
    RET    = 3'd4,
    HOLD   = 3'd5
  } pc_op_t;

  localparam logic [2:0] OPC_NEXT   = 3'd0;
  localparam logic [2:0] OPC_BR_REL = 3'd1;
  localparam logic [2:0] OPC_JMP    = 3'd2;
  localparam logic [2:0] OPC_CALL   = 3'd3;
  localparam logic [2:0] OPC_RET    = 3'd4;
  localparam logic [2:0] OPC_HOLD   = 3'd5;

  // Pointer must represent 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: push writes at sp, pop exposes the entry at sp-1; no error policy here.
// Contents are deliberately left unreset; only the pointer is cleared.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_dat,
  output logic [ADDR_W-1:0] top_dat,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = sp_width(STACK_DEPTH);
  localparam int IDX_W = idx_width(STACK_DEPTH);

  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0] mem_d [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign full    = (sp_q == SP_W'(STACK_DEPTH));
  assign empty   = (sp_q == '0);
  assign wr_idx  = IDX_W'(sp_q);
  assign rd_idx  = IDX_W'(sp_q - 1'b1);
  assign top_dat = mem_q[rd_idx];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_dat;
      sp_d          = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with relative branch, absolute jump and call/return.
// Owns the PC mux and the rejected-call/return decision; the return stack only stores.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic              cond,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] branch_addr,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic              push, pop;
  logic [ADDR_W-1:0] pc_inc, ret_addr;

  assign pc_inc      = pc_q + 1'b1;
  assign branch_addr = pc_q + offset;
  assign pc          = pc_q;
  assign stack_err   = err_q;

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_dat (pc_inc),
    .top_dat  (ret_addr),
    .full     (stack_full),
    .empty    (stack_empty)
  );

  always_comb begin
    pc_d  = pc_q;
    err_d = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (en) begin
      case (op)
        NEXT:   pc_d = pc_inc;
        BR_REL: pc_d = cond ? branch_addr : pc_inc;
        JMP:    pc_d = target;
        CALL: begin
          if (stack_full) err_d = 1'b1;
          else begin
            push = 1'b1;
            pc_d = target;
          end
        end
        RET: begin
          if (stack_empty) err_d = 1'b1;
          else begin
            pop  = 1'b1;
            pc_d = ret_addr;
          end
        end
        default: pc_d = pc_q;  // HOLD and reserved codes
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded directed test for pc_sequencer (ADDR_W=8, STACK_DEPTH=4, RESET_PC=0).
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct packed {
    logic [7:0] pc;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = OPC_HOLD;
  logic       cond = 1'b0;
  logic [7:0] offset = 8'h00;
  logic [7:0] target = 8'h00;
  logic [7:0] pc, branch_addr;
  logic       stack_full, stack_empty, stack_err;

  int checks = 0;
  int failures = 0;
  exp_t  exp_q [$];
  string name_q [$];

  pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .cond(cond), .offset(offset),
    .target(target), .pc(pc), .branch_addr(branch_addr),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_state(input string name, input exp_t e);
    checks++;
    if (pc !== e.pc || stack_full !== e.full || stack_empty !== e.empty || stack_err !== e.err) begin
      failures++;
      $display("FAIL %s: got pc=%h full=%b empty=%b err=%b, expected pc=%h full=%b empty=%b err=%b",
               name, pc, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
    end
  endtask

  // Monitor: every post-edge sample is an output beat while out of reset.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check_state(n, e);
    end
  end

  task automatic step(input string name, input logic e_en, input logic [2:0] e_op,
                      input logic e_cond, input logic [7:0] e_off, input logic [7:0] e_tgt,
                      input logic [7:0] x_pc, input logic x_full, input logic x_empty,
                      input logic x_err);
    en = e_en; op = e_op; cond = e_cond; offset = e_off; target = e_tgt;
    @(posedge clk);
    exp_q.push_back('{pc: x_pc, full: x_full, empty: x_empty, err: x_err});
    name_q.push_back(name);
    @(negedge clk);
  endtask

  task automatic check_ba(input string name, input logic [7:0] off, input logic [7:0] x_ba);
    offset = off;
    #1;
    checks++;
    if (branch_addr !== x_ba) begin
      failures++;
      $display("FAIL %s: got branch_addr=%h, expected %h", name, branch_addr, x_ba);
    end
  endtask

  initial begin
    #3;
    check_state("reset_state", '{pc: 8'h00, full: 1'b0, empty: 1'b1, err: 1'b0});
    check_ba("reset_branch_addr", 8'h03, 8'h03);
    @(negedge clk);
    rst = 1'b0;

    step("next1", 1, OPC_NEXT, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);
    step("next2", 1, OPC_NEXT, 0, 8'h00, 8'h00, 8'h02, 0, 1, 0);
    step("next3", 1, OPC_NEXT, 0, 8'h00, 8'h00, 8'h03, 0, 1, 0);

    step("jmp10", 1, OPC_JMP, 0, 8'h00, 8'h10, 8'h10, 0, 1, 0);
    check_ba("ba_back_taken", 8'hFC, 8'h0C);
    step("br_taken", 1, OPC_BR_REL, 1, 8'hFC, 8'h00, 8'h0C, 0, 1, 0);
    step("jmp10b", 1, OPC_JMP, 0, 8'hFC, 8'h10, 8'h10, 0, 1, 0);
    check_ba("ba_back_not_taken", 8'hFC, 8'h0C);
    step("br_not_taken", 1, OPC_BR_REL, 0, 8'hFC, 8'h00, 8'h11, 0, 1, 0);

    step("jmpFE", 1, OPC_JMP, 0, 8'h00, 8'hFE, 8'hFE, 0, 1, 0);
    check_ba("ba_wrap", 8'h05, 8'h03);
    step("br_wrap", 1, OPC_BR_REL, 1, 8'h05, 8'h00, 8'h03, 0, 1, 0);
    step("jmpFF", 1, OPC_JMP, 0, 8'h00, 8'hFF, 8'hFF, 0, 1, 0);
    step("next_wrap", 1, OPC_NEXT, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);

    step("jmp20", 1, OPC_JMP, 0, 8'h00, 8'h20, 8'h20, 0, 1, 0);
    step("call80", 1, OPC_CALL, 0, 8'h00, 8'h80, 8'h80, 0, 0, 0);
    step("ret21", 1, OPC_RET, 0, 8'h00, 8'h00, 8'h21, 0, 1, 0);

    step("callA0", 1, OPC_CALL, 0, 8'h00, 8'hA0, 8'hA0, 0, 0, 0);
    step("callB0", 1, OPC_CALL, 0, 8'h00, 8'hB0, 8'hB0, 0, 0, 0);
    step("callC0", 1, OPC_CALL, 0, 8'h00, 8'hC0, 8'hC0, 0, 0, 0);
    step("callD0_full", 1, OPC_CALL, 0, 8'h00, 8'hD0, 8'hD0, 1, 0, 0);
    step("call_overflow1", 1, OPC_CALL, 0, 8'h00, 8'hE0, 8'hD0, 1, 0, 1);
    step("call_overflow2", 1, OPC_CALL, 0, 8'h00, 8'hE0, 8'hD0, 1, 0, 1);
    step("hold_clears_err", 1, OPC_HOLD, 0, 8'h00, 8'h00, 8'hD0, 1, 0, 0);

    step("retC1", 1, OPC_RET, 0, 8'h00, 8'h00, 8'hC1, 0, 0, 0);
    step("retB1", 1, OPC_RET, 0, 8'h00, 8'h00, 8'hB1, 0, 0, 0);
    step("retA1", 1, OPC_RET, 0, 8'h00, 8'h00, 8'hA1, 0, 0, 0);
    step("ret22", 1, OPC_RET, 0, 8'h00, 8'h00, 8'h22, 0, 1, 0);
    step("ret_underflow", 1, OPC_RET, 0, 8'h00, 8'h00, 8'h22, 0, 1, 1);
    step("next_after_err", 1, OPC_NEXT, 0, 8'h00, 8'h00, 8'h23, 0, 1, 0);

    step("en0_call1", 0, OPC_CALL, 0, 8'h00, 8'h77, 8'h23, 0, 1, 0);
    step("en0_call2", 0, OPC_CALL, 0, 8'h00, 8'h77, 8'h23, 0, 1, 0);
    step("en0_call3", 0, OPC_CALL, 0, 8'h00, 8'h77, 8'h23, 0, 1, 0);
    step("reserved7", 1, 3'd7, 1, 8'h10, 8'h77, 8'h23, 0, 1, 0);
    step("reserved6", 1, 3'd6, 1, 8'h10, 8'h77, 8'h23, 0, 1, 0);

    step("call40", 1, OPC_CALL, 0, 8'h00, 8'h40, 8'h40, 0, 0, 0);
    step("call50", 1, OPC_CALL, 0, 8'h00, 8'h50, 8'h50, 0, 0, 0);
    // Asynchronous reset between edges with two entries on the stack.
    en = 1'b1; op = OPC_CALL; target = 8'h60;
    #2;
    rst = 1'b1;
    #1;
    check_state("async_reset", '{pc: 8'h00, full: 1'b0, empty: 1'b1, err: 1'b0});
    @(posedge clk);
    #1;
    check_state("reset_held", '{pc: 8'h00, full: 1'b0, empty: 1'b1, err: 1'b0});
    @(negedge clk);
    rst = 1'b0;
    step("next_post_reset", 1, OPC_NEXT, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);
    step("ret_post_reset", 1, OPC_RET, 0, 8'h00, 8'h00, 8'h01, 0, 1, 1);
    step("idle", 1, OPC_HOLD, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer. It replaces the fixed 8-bit combinational branch-address adder with a registered PC and a generalised address width. It adds conditional relative branches, absolute jumps, and call/return through a small hardware return-address stack. The block sits at the front of the fetch path: its `pc` output drives instruction memory, and the decode stage drives its `op`, `cond`, `offset` and `target` inputs.

## Interface
- `ADDR_W`, default 8: width of PC, offset, target and stack entries.
- `STACK_DEPTH`, default 4: number of return-stack entries; must be ≥ 1.
- `RESET_PC`, default 0: PC value loaded on reset.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: advance enable; when 0, all state holds.
- `op`  in  3: operation select, encoding in package.
- `cond`  in  1: branch-taken qualifier; used by BR_REL only.
- `offset`  in  ADDR_W: two's-complement relative displacement.
- `target`  in  ADDR_W: absolute address for JMP and CALL.
- `pc`  out  ADDR_W: current PC, registered.
- `branch_addr`  out  ADDR_W: combinational `pc + offset`, mod 2^ADDR_W.
- `stack_full`  out  1: stack holds STACK_DEPTH entries.
- `stack_empty`  out  1: stack holds 0 entries.
- `stack_err`  out  1: one-cycle pulse on a rejected CALL or RET.

## Operation
Ops are evaluated only when `en`=1. All PC arithmetic wraps mod 2^ADDR_W; no carry or overflow flag exists.
- NEXT (0): `pc <= pc + 1`.
- BR_REL (1): `pc <= cond ? pc + offset : pc + 1`. The offset is relative to the current PC, not PC+1.
- JMP (2): `pc <= target`.
- CALL (3): if not full, push `pc + 1`, `sp <= sp + 1`, `pc <= target`. If full, no push, `pc` holds, `stack_err` pulses.
- RET (4): if not empty, `pc <= stack[sp-1]`, `sp <= sp - 1`. If empty, `pc` holds, `stack_err` pulses.
- HOLD (5), and the reserved codes 6 and 7: `pc` holds, no stack change, no error.
- `en`=0: everything holds regardless of `op`, and `stack_err` is 0.
- Stack pointer `sp` is `$clog2(STACK_DEPTH+1)` bits wide and ranges 0..STACK_DEPTH.
  - `stack_full` = (`sp` == STACK_DEPTH).
  - `stack_empty` = (`sp` == 0).
- Stack contents are not cleared on reset. Entries at or above `sp` are don't-care.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - `pc` = RESET_PC, `sp` = 0.
  - `stack_empty` = 1, `stack_full` = 0, `stack_err` = 0.
  - `branch_addr` follows as RESET_PC + `offset`.
- Reset during any op aborts it. The first edge after `rst` deasserts evaluates normally.
- Latency:
  - `pc` updates on the edge where `en`=1; the new value is visible one cycle later.
  - `branch_addr` is zero-latency combinational from `pc` and `offset`.
- `stack_err` is registered and high for exactly the cycle after the offending edge. Back-to-back rejected ops give consecutive pulses.
- Flags are registered (derived from `sp`) and change in the same cycle as `pc`.
- No ready/valid handshake. Upstream stalls with `en`=0 or HOLD; the block never back-pressures.

## Structure
- Package `pc_seq_pkg` holds:
  - `typedef enum logic [2:0] pc_op_t` with NEXT, BR_REL, JMP, CALL, RET, HOLD.
  - Shared opcode constants used by the decoder.
- Sub-module `ret_stack`: a parametrised LIFO (`ADDR_W`, `STACK_DEPTH`) with push, pop, top, full and empty. It has no internal error logic; `pc_sequencer` owns the error decision and the PC mux.

## Test plan
All scenarios use ADDR_W=8, STACK_DEPTH=4, RESET_PC=0x00.
- Reset, then NEXT×3 with `en`=1: `pc` = 0x00→0x01→0x02→0x03; `stack_empty`=1.
- `pc`=0x10, BR_REL with `offset`=0xFC:
  - `cond`=1 gives `pc`=0x0C.
  - Repeated with `cond`=0 gives 0x11.
  - `branch_addr`=0x0C combinationally before the edge in both cases.
- Wrap: `pc`=0xFE, BR_REL with `cond`=1, `offset`=0x05 gives 0x03. NEXT at 0xFF gives 0x00.
- CALL/RET:
  - At `pc`=0x20, CALL `target`=0x80 gives `pc`=0x80, `sp`=1.
  - RET then gives `pc`=0x21, `stack_empty`=1.
- Stack limits:
  - Five CALLs fill the stack after four. The fifth leaves `pc` unchanged, `stack_full`=1, `stack_err`=1 for one cycle.
  - Four RETs return in LIFO order. A fifth RET holds `pc` and pulses `stack_err`.
- `en`=0 with CALL presented for 3 cycles: no change, no err.
- Assert `rst` mid-sequence with `sp`=2, asynchronously between edges: `pc`=0x00, `sp`=0 immediately.
